hmi_tx: RTL and testbench
=========================

Name: hmi_tx

Overview:
Host-interface response transmitter, the return path of the HMI command decoder. On a read strobe it fetches one register word, then sends a framed byte stream to the host: a header byte followed by the data bytes. On a status request it sends the FPGA-select status byte instead. Each byte uses the same byte-plus-ready-strobe handshake the host side uses toward the FPGA, so the host can reuse its synchronizer and edge detector. It sits beside the command decoder and the register bank, and drives the shared host bus only when this FPGA is selected.

Parameters:
DATA_BYTES, 4, number of data bytes per read frame (1..4); rd_data width is 8*DATA_BYTES.
STROBE_LEN, 4, cycles dout_rdy is held high per byte (minimum 2).
GAP_LEN, 4, cycles dout_rdy is held low after each strobe (minimum 2).

Ports:
clk  in  1  system clock
res  in  1  synchronous active-high reset
read  in  1  one-cycle read request (from the decoder's read output)
address  in  6  register address, sampled with read
send_status  in  1  one-cycle status-frame request
status  in  8  fpga_sel_status byte, sampled with send_status
fpga_sel  in  1  this FPGA is selected on the host bus
rd_en  out  1  register-bank read enable, one cycle
rd_addr  out  6  register-bank address
rd_data  in  8*DATA_BYTES  register word, valid the cycle after rd_en
dout  out  8  byte to host
dout_rdy  out  1  byte-ready strobe
dout_oe  out  1  bus output enable
busy  out  1  frame in progress
overrun  out  1  sticky flag: a request was dropped
clr_ovr  in  1  clears overrun

Behaviour:
- Clock and reset: one clock, clk. res is synchronous and active-high. On res every output is 0, state returns to IDLE and all counters clear.
- Reset mid-frame: the frame is abandoned. On the next edge dout_rdy, dout_oe and busy are 0 and dout is 0x00. No partial byte is completed.
- States: IDLE, FETCH, LOAD, STROBE, GAP.
- IDLE, read=1, fpga_sel=1:
  - latch address into rd_addr; go to FETCH.
  - FETCH: rd_en=1 for exactly one cycle.
  - LOAD: capture rd_data into the frame register.
  - Frame = header {2'b10, rd_addr}, then rd_data bytes MSB first.
- IDLE, send_status=1, fpga_sel=1:
  - latch status; go directly to LOAD.
  - Frame = header 8'hC0, then the status byte (2 bytes).
- IDLE, request while fpga_sel=0: ignored completely; overrun is not set.
- Byte timing:
  - STROBE: dout = current byte, dout_rdy=1 for STROBE_LEN cycles.
  - GAP: dout_rdy=0 for GAP_LEN cycles while dout holds the byte.
  - After GAP, advance the byte index. After the last byte, go to IDLE.
  - dout changes only on entry to STROBE.
- busy is 1 from the cycle after the accepted request until the cycle IDLE is re-entered.
- Frame lengths:
  - Read frame: busy for 2 + (1+DATA_BYTES)*(STROBE_LEN+GAP_LEN) cycles. The first dout_rdy rises 3 cycles after read.
  - Status frame: busy for 1 + 2*(STROBE_LEN+GAP_LEN) cycles.
- dout_oe: equals busy while fpga_sel was 1 when the request was accepted. It is latched, so a fpga_sel change mid-frame has no effect.
- Dropped requests:
  - read or send_status while busy: dropped; overrun=1.
  - read and send_status in the same IDLE cycle: read wins, send_status is dropped, overrun=1.
- overrun is sticky until clr_ovr=1. If clr_ovr and a new drop occur in the same cycle, set wins.
- Counters:
  - Strobe/gap counter width is clog2(max(STROBE_LEN,GAP_LEN)). It must not wrap within a phase.
  - Byte index width is 3 bits. Last index is DATA_BYTES for read frames and 1 for status frames.
- Elaboration error if STROBE_LEN<2, GAP_LEN<2, or DATA_BYTES outside 1..4.

Decomposition:
- Shared package hmi_pkg holds:
  - opcode constants OP_CMD=2'b01, OP_ADDR=2'b10, OP_SEL=2'b11;
  - header constants HDR_READ=2'b10 and HDR_STATUS=8'hC0;
  - the hmi_tx state encoding.
- One sub-module, hmi_strobe_timer: loadable down-counter that produces the phase-done pulse for STROBE/GAP, parameterised by length.

Test Plan:
1. read, address=6'h05, rd_data=32'hDEADBEEF, fpga_sel=1 -> dout sequence 0x85, DE, AD, BE, EF; each byte with dout_rdy high 4 and low 4 cycles; rd_en exactly once, on cycle +1; busy and dout_oe high 42 cycles.
2. send_status, status=8'hB5 -> bytes 0xC0, 0xB5; busy high 17 cycles; rd_en never asserted.
3. read, then a second read 10 cycles later -> second read dropped, overrun=1, first frame unaltered; clr_ovr pulse -> overrun=0 next cycle.
4. read with fpga_sel=0 -> busy, dout_oe, dout_rdy, rd_en stay 0; overrun stays 0.
5. res asserted during the STROBE of byte 2 -> next cycle dout_rdy=0, busy=0, dout=0x00; a following read produces a complete, correct frame.
6. read and send_status in the same cycle (address=6'h3F, rd_data=32'h01020304) -> frame 0xBF, 01, 02, 03, 04; overrun=1.

Source files
------------

// File: rtl/hmi_pkg.sv
// Shared HMI constants: decoder opcodes, response frame headers and the
// hmi_tx state encoding.
package hmi_pkg;

    localparam logic [1:0] OP_CMD     = 2'b01;
    localparam logic [1:0] OP_ADDR    = 2'b10;
    localparam logic [1:0] OP_SEL     = 2'b11;

    localparam logic [1:0] HDR_READ   = 2'b10;
    localparam logic [7:0] HDR_STATUS = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STROBE,
        ST_GAP
    } hmi_tx_state_e;

endpackage

// File: rtl/hmi_strobe_timer.sv
// Phase timer for the byte handshake: loads the strobe or gap length and
// flags the final cycle of the phase.
module hmi_strobe_timer #(
    parameter int STROBE_LEN = 4,
    parameter int GAP_LEN    = 4
) (
    input  logic i_clk,
    input  logic i_res,
    input  logic i_load_strobe,
    input  logic i_load_gap,
    output logic o_done
);

    localparam int MAX_LEN = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN);

    logic [CNT_W-1:0] r_cnt;

    // Loaded with LEN-1 so the counter never holds LEN and cannot wrap.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_cnt <= '0;
        end else if (i_load_strobe) begin
            r_cnt <= CNT_W'(STROBE_LEN - 1);
        end else if (i_load_gap) begin
            r_cnt <= CNT_W'(GAP_LEN - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/hmi_tx.sv
// HMI response transmitter: fetches a register word (or takes the status
// byte) and returns it to the host as a header-framed strobed byte stream.
module hmi_tx
    import hmi_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int STROBE_LEN = 4,
    parameter int GAP_LEN    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_res,
    input  logic                    i_read,
    input  logic [5:0]              i_address,
    input  logic                    i_send_status,
    input  logic [7:0]              i_status,
    input  logic                    i_fpga_sel,
    output logic                    o_rd_en,
    output logic [5:0]              o_rd_addr,
    input  logic [8*DATA_BYTES-1:0] i_rd_data,
    output logic [7:0]              o_dout,
    output logic                    o_dout_rdy,
    output logic                    o_dout_oe,
    output logic                    o_busy,
    output logic                    o_overrun,
    input  logic                    i_clr_ovr
);

    if (DATA_BYTES < 1 || DATA_BYTES > 4 || STROBE_LEN < 2 || GAP_LEN < 2) begin : g_bad_params
        $error("hmi_tx: DATA_BYTES must be 1..4, STROBE_LEN and GAP_LEN at least 2");
    end

    localparam int         FW      = 8 * (DATA_BYTES + 1);
    localparam logic [2:0] LAST_RD = 3'(DATA_BYTES);

    hmi_tx_state_e r_state, w_state_nxt;

    logic [5:0]    r_rd_addr;
    logic [7:0]    r_status;
    logic          r_is_status;
    logic          r_oe;
    logic [FW-1:0] r_frame;
    logic [7:0]    r_dout;
    logic [2:0]    r_idx;
    logic          r_ovr;

    logic          w_idle, w_acc_rd, w_acc_st, w_drop;
    logic          w_done, w_last, w_enter_gap, w_phase_end, w_enter_strobe;
    logic [FW-1:0] w_frame_load, w_frame_src;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_acc_rd = w_idle && i_fpga_sel && i_read;
    assign w_acc_st = w_idle && i_fpga_sel && i_send_status && !i_read;
    // Deselected idle requests are not ours to answer, so they never count as drops.
    assign w_drop   = (!w_idle && (i_read || i_send_status)) ||
                      (w_idle && i_fpga_sel && i_read && i_send_status);

    assign w_last         = (r_idx == (r_is_status ? 3'd1 : LAST_RD));
    assign w_enter_gap    = (r_state == ST_STROBE) && w_done;
    assign w_phase_end    = (r_state == ST_GAP) && w_done;
    assign w_enter_strobe = (r_state == ST_LOAD) || (w_phase_end && !w_last);

    assign w_frame_load = r_is_status ? (FW'({HDR_STATUS, r_status}) << (FW - 16))
                                      : {HDR_READ, r_rd_addr, i_rd_data};
    assign w_frame_src  = (r_state == ST_LOAD) ? w_frame_load : r_frame;

    hmi_strobe_timer #(
        .STROBE_LEN (STROBE_LEN),
        .GAP_LEN    (GAP_LEN)
    ) u_timer (
        .i_clk         (i_clk),
        .i_res         (i_res),
        .i_load_strobe (w_enter_strobe),
        .i_load_gap    (w_enter_gap),
        .o_done        (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_res) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_rd)      w_state_nxt = ST_FETCH;
                else if (w_acc_st) w_state_nxt = ST_LOAD;
            end
            ST_FETCH:  w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_STROBE;
            ST_STROBE: if (w_done) w_state_nxt = ST_GAP;
            ST_GAP:    if (w_done) w_state_nxt = w_last ? ST_IDLE : ST_STROBE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_rd_addr   <= '0;
            r_status    <= '0;
            r_is_status <= 1'b0;
            r_oe        <= 1'b0;
            r_frame     <= '0;
            r_dout      <= '0;
            r_idx       <= '0;
            r_ovr       <= 1'b0;
        end else begin
            if (w_acc_rd) begin
                r_rd_addr   <= i_address;
                r_is_status <= 1'b0;
                r_oe        <= i_fpga_sel;
            end else if (w_acc_st) begin
                r_status    <= i_status;
                r_is_status <= 1'b1;
                r_oe        <= i_fpga_sel;
            end
            // Bytes leave MSB first: present the top byte, shift the rest up.
            if (w_enter_strobe) begin
                r_dout  <= w_frame_src[FW-1 -: 8];
                r_frame <= w_frame_src << 8;
            end
            if (r_state == ST_LOAD)        r_idx <= '0;
            else if (w_phase_end && !w_last) r_idx <= r_idx + 3'd1;
            if (w_drop)         r_ovr <= 1'b1;
            else if (i_clr_ovr) r_ovr <= 1'b0;
        end
    end

    assign o_busy     = !w_idle;
    assign o_rd_en    = (r_state == ST_FETCH);
    assign o_rd_addr  = r_rd_addr;
    assign o_dout     = r_dout;
    assign o_dout_rdy = (r_state == ST_STROBE);
    assign o_dout_oe  = o_busy && r_oe;
    assign o_overrun  = r_ovr;

endmodule

// File: tb/tb_hmi_tx.sv
// Bench for hmi_tx: frame-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized request traffic.
module tb_hmi_tx;

    localparam int DB  = 4;
    localparam int SL  = 4;
    localparam int GL  = 4;
    localparam int PER = SL + GL;

    typedef logic [8*DB-1:0] word_t;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       read = 1'b0;
    logic [5:0] address = '0;
    logic       send_status = 1'b0;
    logic [7:0] status = '0;
    logic       fpga_sel = 1'b1;
    logic       clr_ovr = 1'b0;
    logic       rd_en;
    logic [5:0] rd_addr;
    word_t      rd_data = '0;
    logic [7:0] dout;
    logic       dout_rdy, dout_oe, busy, overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hmi_tx #(.DATA_BYTES(DB), .STROBE_LEN(SL), .GAP_LEN(GL)) dut (
        .i_clk         (clk),
        .i_res         (res),
        .i_read        (read),
        .i_address     (address),
        .i_send_status (send_status),
        .i_status      (status),
        .i_fpga_sel    (fpga_sel),
        .o_rd_en       (rd_en),
        .o_rd_addr     (rd_addr),
        .i_rd_data     (rd_data),
        .o_dout        (dout),
        .o_dout_rdy    (dout_rdy),
        .o_dout_oe     (dout_oe),
        .o_busy        (busy),
        .o_overrun     (overrun),
        .i_clr_ovr     (clr_ovr)
    );

    // Register bank: data valid only in the cycle after rd_en, garbage otherwise.
    word_t mem [0:63];
    initial forever begin
        @(posedge clk);
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= word_t'($urandom);
    end

    // Frame-level model: m_k counts busy cycles since acceptance (0 = idle).
    int         cyc = 0;
    int         m_k = 0, m_len = 0, m_p0 = 0;
    bit         m_is_read = 0, m_ovr = 0;
    logic [7:0] m_dout = '0;
    logic [5:0] m_addr = '0;
    logic [7:0] m_bytes [0:DB];

    int         mon_req_cyc = -1, mon_rden_cyc = -1, mon_rdy_cyc = -1;
    int         mon_busy = 0, mon_rden = 0;
    bit         mon_prev_rdy = 0;
    logic [7:0] mon_bytes [$];
    logic [7:0] exp_b [0:4];

    task automatic model_step();
        bit drop = 0;
        if (res) begin
            m_k = 0; m_dout = '0; m_ovr = 0; m_addr = '0; m_is_read = 0;
            return;
        end
        if (m_k != 0) begin
            drop = read || send_status;
            m_k++;
            if (m_k > m_len) m_k = 0;
        end else if (fpga_sel && (read || send_status)) begin
            if (mon_req_cyc < 0) mon_req_cyc = cyc;
            m_k = 1;
            if (read) begin
                word_t w = mem[address];
                m_is_read  = 1;
                m_addr     = address;
                m_len      = 2 + (DB + 1) * PER;
                m_p0       = 3;
                m_bytes[0] = {2'b10, address};
                for (int j = 0; j < DB; j++) m_bytes[j+1] = w[8*(DB-1-j) +: 8];
                drop = send_status;
            end else begin
                m_is_read  = 0;
                m_len      = 1 + 2 * PER;
                m_p0       = 2;
                m_bytes[0] = 8'hC0;
                m_bytes[1] = status;
            end
        end
        if (drop)         m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
        if (m_k != 0 && m_k >= m_p0 && ((m_k - m_p0) % PER) == 0)
            m_dout = m_bytes[(m_k - m_p0) / PER];
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        cyc++;
    end

    task automatic check_cycle();
        bit e_busy = (m_k != 0);
        bit e_rdy  = e_busy && (m_k >= m_p0) && (((m_k - m_p0) % PER) < SL);
        bit e_rden = e_busy && m_is_read && (m_k == 1);
        checks++;
        if ({busy, dout_oe, dout_rdy, rd_en, overrun, dout, rd_addr} !==
            {e_busy, e_busy, e_rdy, e_rden, m_ovr, m_dout, m_addr}) begin
            errors++;
            $display("FAIL cycle %0d outputs: got busy=%b oe=%b rdy=%b rd_en=%b ovr=%b dout=%h rd_addr=%h, expected busy=%b oe=%b rdy=%b rd_en=%b ovr=%b dout=%h rd_addr=%h",
                     cyc, busy, dout_oe, dout_rdy, rd_en, overrun, dout, rd_addr,
                     e_busy, e_busy, e_rdy, e_rden, m_ovr, m_dout, m_addr);
        end
        if (busy) mon_busy++;
        if (rd_en) begin
            mon_rden++;
            if (mon_rden_cyc < 0) mon_rden_cyc = cyc;
        end
        if (dout_rdy && !mon_prev_rdy) begin
            mon_bytes.push_back(dout);
            if (mon_rdy_cyc < 0) mon_rdy_cyc = cyc;
        end
        mon_prev_rdy = dout_rdy;
    endtask

    initial forever begin
        @(negedge clk);
        check_cycle();
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bytes(input string name, input int n);
        bit bad = (mon_bytes.size() != n);
        checks++;
        if (!bad) for (int j = 0; j < n; j++) if (mon_bytes[j] !== exp_b[j]) bad = 1;
        if (bad) begin
            errors++;
            $display("FAIL %s: got %0d bytes %p expected %0d bytes %p", name, mon_bytes.size(), mon_bytes, n, exp_b);
        end
    endtask

    task automatic mon_clear();
        mon_req_cyc = -1; mon_rden_cyc = -1; mon_rdy_cyc = -1;
        mon_busy = 0; mon_rden = 0;
        mon_bytes.delete();
    endtask

    task automatic pulse_read(input logic [5:0] a);
        @(negedge clk); read = 1'b1; address = a;
        @(negedge clk); read = 1'b0;
    endtask

    task automatic pulse_status(input logic [7:0] s);
        @(negedge clk); send_status = 1'b1; status = s;
        @(negedge clk); send_status = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, busy=%b expected 0", name, busy);
        end
        @(negedge clk);
    endtask

    initial begin
        word_t w;
        for (int i = 0; i < 64; i++) mem[i] = word_t'($urandom);
        mem[6'h05] = 32'hDEADBEEF;
        mem[6'h3F] = 32'h01020304;

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset dout", dout, 0);
        chk("reset rdy", dout_rdy, 0);
        chk("reset oe", dout_oe, 0);
        chk("reset overrun", overrun, 0);
        res = 1'b0;
        @(negedge clk);

        // Read frame
        mon_clear();
        pulse_read(6'h05);
        wait_idle("t1 idle");
        exp_b = '{8'h85, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        chk_bytes("t1 bytes", 5);
        chk("t1 busy cycles", mon_busy, 42);
        chk("t1 rd_en count", mon_rden, 1);
        chk("t1 rd_en offset", mon_rden_cyc - mon_req_cyc, 1);
        chk("t1 first rdy offset", mon_rdy_cyc - mon_req_cyc, 3);

        // Status frame
        mon_clear();
        pulse_status(8'hB5);
        wait_idle("t2 idle");
        exp_b = '{8'hC0, 8'hB5, 8'h00, 8'h00, 8'h00};
        chk_bytes("t2 bytes", 2);
        chk("t2 busy cycles", mon_busy, 17);
        chk("t2 rd_en count", mon_rden, 0);
        chk("t2 first rdy offset", mon_rdy_cyc - mon_req_cyc, 2);

        // Read while busy is dropped
        mon_clear();
        pulse_read(6'h12);
        repeat (8) @(negedge clk);
        pulse_read(6'h07);
        chk("t3 overrun set", overrun, 1);
        wait_idle("t3 idle");
        w = mem[6'h12];
        exp_b[0] = {2'b10, 6'h12};
        for (int j = 0; j < DB; j++) exp_b[j+1] = w[8*(DB-1-j) +: 8];
        chk_bytes("t3 bytes", 5);
        chk("t3 busy cycles", mon_busy, 42);
        chk("t3 overrun sticky", overrun, 1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("t3 overrun cleared", overrun, 0);

        // Deselected read is ignored
        fpga_sel = 1'b0;
        mon_clear();
        pulse_read(6'h05);
        repeat (50) @(negedge clk);
        chk("t4 busy cycles", mon_busy, 0);
        chk("t4 rd_en count", mon_rden, 0);
        chk("t4 bytes", mon_bytes.size(), 0);
        chk("t4 overrun", overrun, 0);
        fpga_sel = 1'b1;

        // Reset during the strobe of byte 2
        mon_clear();
        pulse_read(6'h05);
        for (int n = 0; n < 100 && mon_bytes.size() < 3; n++) @(negedge clk);
        chk("t5 reached byte 2", mon_bytes.size(), 3);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        chk("t5 rdy after reset", dout_rdy, 0);
        chk("t5 busy after reset", busy, 0);
        chk("t5 dout after reset", dout, 0);
        @(negedge clk);
        mon_clear();
        pulse_read(6'h05);
        wait_idle("t5 idle");
        exp_b = '{8'h85, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        chk_bytes("t5 bytes", 5);
        chk("t5 busy cycles", mon_busy, 42);

        // Simultaneous read and status: read wins
        mon_clear();
        @(negedge clk);
        read = 1'b1; send_status = 1'b1; address = 6'h3F; status = 8'h11;
        @(negedge clk);
        read = 1'b0; send_status = 1'b0;
        wait_idle("t6 idle");
        exp_b = '{8'hBF, 8'h01, 8'h02, 8'h03, 8'h04};
        chk_bytes("t6 bytes", 5);
        chk("t6 overrun", overrun, 1);
        chk("t6 busy cycles", mon_busy, 42);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            read        = ($urandom % 20) == 0;
            send_status = ($urandom % 24) == 0;
            fpga_sel    = ($urandom % 6) != 0;
            address     = 6'($urandom);
            status      = 8'($urandom);
            clr_ovr     = ($urandom % 40) == 0;
            res         = ($urandom % 600) == 0;
        end
        @(negedge clk);
        read = 1'b0; send_status = 1'b0; clr_ovr = 1'b0; res = 1'b0; fpga_sel = 1'b1;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
